ship_mover: RTL and testbench

//  Parametrised player-sprite motion engine for the 640x480 VGA playfield.

---
 rtl/ship_mover.sv | 173 +++++++++++++++++
 tb/tb_ship_mover.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ship_mover.sv
// Player-sprite motion engine: joystick-driven velocity with accel/friction/cap,
// guard-ring collision sensing, edge clamp (or wrap when SHIP_WRAP_EN is defined).
module ship_mover #(
    parameter int XLOC_START = 375,
    parameter int YLOC_START = 440,
    parameter int HALF_W     = 7,
    parameter int HALF_H     = 2,
    parameter int GAP        = 2,
    parameter int ACCEL      = 1,
    parameter int VMAX       = 4,
    parameter int VW         = 4,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pixpulse,
    input  logic [9:0]    hcount,
    input  logic [9:0]    vcount,
    input  logic          empty,
    input  logic          move,
    input  logic          mU,
    input  logic          mD,
    input  logic          mL,
    input  logic          mR,
    output logic          draw_ship,
    output logic [9:0]    xloc,
    output logic [9:0]    yloc,
    output logic [VW-1:0] xvel,
    output logic [VW-1:0] yvel,
    output logic          hit
);

    localparam logic signed [11:0] HW = 12'(HALF_W);
    localparam logic signed [11:0] HH = 12'(HALF_H);
    localparam logic signed [11:0] GP = 12'(GAP);
    localparam logic signed [11:0] AC = 12'(ACCEL);
    localparam logic signed [11:0] VM = 12'(VMAX);
    localparam logic signed [11:0] SW = 12'(SCREEN_W);
    localparam logic signed [11:0] SH = 12'(SCREEN_H);

    typedef struct packed {
        logic             stop;
        logic signed [11:0] pos;
    } axis_t;

    logic signed [VW-1:0] xv_q, yv_q;
    logic                 blk_r, blk_l, blk_u, blk_d, ovl;
    logic signed [11:0]   dx, dy;
    logic                 in_x, in_y;
    logic                 sense_r, sense_l, sense_u, sense_d;
    logic signed [11:0]   vx_ext, vy_ext, vx_n, vy_n;
    axis_t                ax, ay;

    function automatic logic signed [11:0] next_vel(input logic signed [11:0] v,
                                                    input logic pos_btn,
                                                    input logic neg_btn);
        logic signed [11:0] t;
        t = v;
        if (pos_btn && !neg_btn) begin
            t = v + AC;
            if (t > VM) t = VM;
        end else if (neg_btn && !pos_btn) begin
            t = v - AC;
            if (t < -VM) t = -VM;
        end else if (v > 12'sd0) begin
            t = v - 12'sd1;
        end else if (v < 12'sd0) begin
            t = v + 12'sd1;
        end
        return t;
    endfunction

    // stop=1 means the axis velocity must be zeroed (blocked or clamped).
    function automatic axis_t step_axis(input logic [9:0] pos,
                                        input logic signed [11:0] v,
                                        input logic blk_pos,
                                        input logic blk_neg,
                                        input logic signed [11:0] half,
                                        input logic signed [11:0] span);
        axis_t o;
        o.stop = 1'b0;
        o.pos  = $signed({2'b00, pos}) + v;
        if ((v > 12'sd0 && blk_pos) || (v < 12'sd0 && blk_neg)) begin
            o.stop = 1'b1;
            o.pos  = $signed({2'b00, pos});
        end else begin
`ifdef SHIP_WRAP_EN
            if (o.pos < 12'sd0) o.pos = o.pos + span;
            else if (o.pos >= span) o.pos = o.pos - span;
`else
            if (o.pos < half) begin
                o.pos  = half;
                o.stop = 1'b1;
            end else if (o.pos > span - 12'sd1 - half) begin
                o.pos  = span - 12'sd1 - half;
                o.stop = 1'b1;
            end
`endif
        end
        return o;
    endfunction

    // Scan-point offset from the ship centre, taken the short way round when wrapping.
    always_comb begin
        dx = $signed({2'b00, hcount}) - $signed({2'b00, xloc});
        dy = $signed({2'b00, vcount}) - $signed({2'b00, yloc});
`ifdef SHIP_WRAP_EN
        if (dx > (SW >>> 1)) dx = dx - SW;
        else if (dx < -(SW >>> 1)) dx = dx + SW;
        if (dy > (SH >>> 1)) dy = dy - SH;
        else if (dy < -(SH >>> 1)) dy = dy + SH;
`endif
    end

    assign in_x      = (dx >= -HW) && (dx <= HW);
    assign in_y      = (dy >= -HH) && (dy <= HH);
    assign draw_ship = in_x && in_y;
    assign sense_r   = (dx == HW + GP) && in_y;
    assign sense_l   = (dx == -(HW + GP)) && in_y;
    assign sense_d   = (dy == HH + GP) && in_x;
    assign sense_u   = (dy == -(HH + GP)) && in_x;

    always_comb begin
        vx_ext = {{(12-VW){xv_q[VW-1]}}, xv_q};
        vy_ext = {{(12-VW){yv_q[VW-1]}}, yv_q};
        vx_n   = next_vel(vx_ext, mR, mL);
        vy_n   = next_vel(vy_ext, mD, mU);
        ax     = step_axis(xloc, vx_n, blk_r, blk_l, HW, SW);
        ay     = step_axis(yloc, vy_n, blk_d, blk_u, HH, SH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xloc  <= 10'(XLOC_START);
            yloc  <= 10'(YLOC_START);
            xv_q  <= '0;
            yv_q  <= '0;
            hit   <= 1'b0;
            blk_r <= 1'b0;
            blk_l <= 1'b0;
            blk_u <= 1'b0;
            blk_d <= 1'b0;
            ovl   <= 1'b0;
        end else if (pixpulse) begin
            if (move) begin
                xloc  <= ax.pos[9:0];
                yloc  <= ay.pos[9:0];
                xv_q  <= ax.stop ? '0 : vx_n[VW-1:0];
                yv_q  <= ay.stop ? '0 : vy_n[VW-1:0];
                hit   <= ovl;
                blk_r <= 1'b0;
                blk_l <= 1'b0;
                blk_u <= 1'b0;
                blk_d <= 1'b0;
                ovl   <= 1'b0;
            end else begin
                hit <= 1'b0;
                if (!empty) begin
                    blk_r <= blk_r | sense_r;
                    blk_l <= blk_l | sense_l;
                    blk_u <= blk_u | sense_u;
                    blk_d <= blk_d | sense_d;
                    ovl   <= ovl | draw_ship;
                end
            end
        end
    end

    assign xvel = xv_q;
    assign yvel = yv_q;

endmodule

// File: tb/tb_ship_mover.sv
// Self-checking bench for ship_mover: directed scenarios plus randomized frames
// compared against an integer reference model.
module tb_ship_mover;

    localparam int HALF_W   = 7;
    localparam int HALF_H   = 2;
    localparam int GAP      = 2;
    localparam int ACCEL    = 1;
    localparam int VMAX     = 4;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int XS       = 375;
    localparam int YS       = 440;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pixpulse = 1'b0;
    logic [9:0] hcount = '0;
    logic [9:0] vcount = '0;
    logic       empty = 1'b1;
    logic       move = 1'b0;
    logic       mU = 1'b0, mD = 1'b0, mL = 1'b0, mR = 1'b0;
    logic       draw_ship;
    logic [9:0] xloc, yloc;
    logic [3:0] xvel, yvel;
    logic       hit;

    ship_mover dut (
        .clk(clk), .rst_n(rst_n), .pixpulse(pixpulse),
        .hcount(hcount), .vcount(vcount), .empty(empty), .move(move),
        .mU(mU), .mD(mD), .mL(mL), .mR(mR),
        .draw_ship(draw_ship), .xloc(xloc), .yloc(yloc),
        .xvel(xvel), .yvel(yvel), .hit(hit)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_x, m_y, m_vx, m_vy;
    bit m_br, m_bl, m_bu, m_bd, m_ov, m_hit;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int norm(input int d, input int span);
`ifdef SHIP_WRAP_EN
        if (d > span / 2) return d - span;
        if (d < -(span / 2)) return d + span;
`endif
        if (span < 0) return 0;
        return d;
    endfunction

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    task automatic model_reset();
        m_x = XS; m_y = YS; m_vx = 0; m_vy = 0;
        m_br = 0; m_bl = 0; m_bu = 0; m_bd = 0; m_ov = 0; m_hit = 0;
    endtask

    task automatic model_axis(inout int p, inout int v, input bit pb, input bit nb,
                              input bit bp, input bit bn, input int half, input int span);
        if (pb && !nb)      v = (v + ACCEL > VMAX) ? VMAX : v + ACCEL;
        else if (nb && !pb) v = (v - ACCEL < -VMAX) ? -VMAX : v - ACCEL;
        else if (v > 0)     v = v - 1;
        else if (v < 0)     v = v + 1;
        if ((v > 0 && bp) || (v < 0 && bn)) begin
            v = 0;
        end else begin
            p = p + v;
`ifdef SHIP_WRAP_EN
            p = (p + span) % span;
`else
            if (p < half) begin p = half; v = 0; end
            if (p > span - 1 - half) begin p = span - 1 - half; v = 0; end
`endif
        end
    endtask

    task automatic model_move();
        model_axis(m_x, m_vx, mR, mL, m_br, m_bl, HALF_W, SCREEN_W);
        model_axis(m_y, m_vy, mD, mU, m_bd, m_bu, HALF_H, SCREEN_H);
        m_hit = m_ov;
        m_br = 0; m_bl = 0; m_bu = 0; m_bd = 0; m_ov = 0;
    endtask

    function automatic bit model_draw(input int h, input int v);
        return iabs(norm(h - m_x, SCREEN_W)) <= HALF_W && iabs(norm(v - m_y, SCREEN_H)) <= HALF_H;
    endfunction

    task automatic model_sense(input int h, input int v);
        int dx, dy;
        dx = norm(h - m_x, SCREEN_W);
        dy = norm(v - m_y, SCREEN_H);
        if (dx == HALF_W + GAP && iabs(dy) <= HALF_H)    m_br = 1;
        if (dx == -(HALF_W + GAP) && iabs(dy) <= HALF_H) m_bl = 1;
        if (dy == HALF_H + GAP && iabs(dx) <= HALF_W)    m_bd = 1;
        if (dy == -(HALF_H + GAP) && iabs(dx) <= HALF_W) m_bu = 1;
        if (iabs(dx) <= HALF_W && iabs(dy) <= HALF_H)    m_ov = 1;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".xloc"}, xloc, m_x);
        check({tag, ".yloc"}, yloc, m_y);
        check({tag, ".xvel"}, $signed(xvel), m_vx);
        check({tag, ".yvel"}, $signed(yvel), m_vy);
        check({tag, ".hit"}, hit, m_hit);
    endtask

    // One pixpulse-qualified clock, then one idle clock.
    task automatic pix(input int h, input int v, input bit e, input bit mv);
        @(negedge clk);
        hcount = h[9:0]; vcount = v[9:0]; empty = e; move = mv; pixpulse = 1'b1;
        #1 check("draw_ship", draw_ship, model_draw(h, v));
        @(posedge clk);
        #1;
        pixpulse = 1'b0; move = 1'b0; empty = 1'b1;
        if (mv) begin
            model_move();
            check_all("move");
        end else begin
            m_hit = 0;
            if (!e) model_sense(h, v);
            check("hit_idle", hit, m_hit);
        end
        @(posedge clk);
    endtask

    task automatic tick();
        pix(m_x, m_y, 1'b1, 1'b1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic int fold(input int a, input int span);
        if (a < 0) return a + span;
        if (a >= span) return a - span;
        return a;
    endfunction

    int exp_v[6] = '{1, 2, 3, 4, 4, 4};
    int exp_x[6] = '{376, 378, 381, 385, 389, 393};
    int rel_v[4] = '{3, 2, 1, 0};

    initial begin
        model_reset();
        apply_reset();
        check_all("reset");

        // Idle frames: nothing moves.
        repeat (3) begin
            repeat (4) pix($urandom_range(0, 639), $urandom_range(0, 479), 1'b1, 1'b0);
            tick();
        end
        check("idle.xloc", xloc, 375);
        check("idle.yloc", yloc, 440);

        // Acceleration to the cap, then friction.
        mR = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("accel.xvel", $signed(xvel), exp_v[i]);
            check("accel.xloc", xloc, exp_x[i]);
        end
        mR = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("fric.xvel", $signed(xvel), rel_v[i]);
        end

        // Right-side obstacle blocks rightward motion only.
        apply_reset();
        mR = 1'b1;
        repeat (2) tick();
        mR = 1'b0;
        pix(m_x + HALF_W + GAP, m_y, 1'b0, 1'b0);
        tick();
        check("block.xvel", $signed(xvel), 0);
        check("block.xloc", xloc, 378);
        pix(m_x + HALF_W + GAP, m_y, 1'b0, 1'b0);
        mL = 1'b1;
        tick();
        mL = 1'b0;
        check("block_left.xvel", $signed(xvel), -1);
        check("block_left.xloc", xloc, 377);

        // Body overlap produces a single-interval hit pulse.
        pix(m_x, m_y, 1'b0, 1'b0);
        tick();
        check("hit.pulse", hit, 1);
        pix(m_x, m_y, 1'b1, 1'b0);
        check("hit.clear", hit, 0);

        // Run into the right screen edge.
        apply_reset();
        mR = 1'b1;
        repeat (70) tick();
        mR = 1'b0;
`ifndef SHIP_WRAP_EN
        check("edge.xloc", xloc, 632);
        check("edge.xvel", $signed(xvel), 0);
`endif

        // Asynchronous reset mid-frame discards a pending left block.
        apply_reset();
        pix(m_x - HALF_W - GAP, m_y, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mL = 1'b1;
        tick();
        mL = 1'b0;
        check("post_rst.xvel", $signed(xvel), -1);
        check("post_rst.xloc", xloc, 374);

        // Randomized frames.
        for (int f = 0; f < 150; f++) begin
            mU = 1'($urandom_range(0, 1));
            mD = 1'($urandom_range(0, 1));
            mL = 1'($urandom_range(0, 1));
            mR = 1'($urandom_range(0, 1));
            for (int p = 0; p < 6; p++) begin
                int h, v;
                if ($urandom_range(0, 3) == 0) begin
                    h = $urandom_range(0, SCREEN_W - 1);
                    v = $urandom_range(0, SCREEN_H - 1);
                end else begin
                    h = fold(m_x + int'($urandom_range(0, 24)) - 12, SCREEN_W);
                    v = fold(m_y + int'($urandom_range(0, 10)) - 5, SCREEN_H);
                end
                pix(h, v, 1'($urandom_range(0, 2) != 0), 1'b0);
            end
            tick();
        end
        mU = 1'b0; mD = 1'b0; mL = 1'b0; mR = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
